sram_arbiter: RTL and testbench

Two-master arbiter placed in front of the 8 KB scratchpad SRAM controller. It shares the single-cycle SRAM port between the CPU data port and the DMA engine, and supports locked DMA bursts with a beat cap. Fixed CPU priority is used, with a starvation override for the DMA. Read data is returned through registered per-master response channels.

---
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - CPU/DMA arbiter in front of the scratchpad SRAM port
// Fixed CPU priority with DMA starvation override, capped locked DMA bursts, registered read responses.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [12:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [3:0]  dma_be,
  input  logic [12:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        sram_req,
  output logic        sram_we,
  output logic [3:0]  sram_be,
  output logic [12:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready,
  input  logic        pd_en,
  input  logic        ret_en,
  input  logic        mbist_en,
  output logic        dma_burst_active
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BURST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BURST, OFFLINE} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          force_q, force_d;
  logic          avail, dma_win, cpu_win;
  logic          cpu_rvalid_q, dma_rvalid_q;
  logic [31:0]   cpu_rdata_q, dma_rdata_q;

  assign avail = pd_en & ~ret_en & ~mbist_en & sram_ready;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    force_d  = 1'b0;
    dma_win  = 1'b0;
    cpu_win  = 1'b0;
    if (!avail) begin
      state_d = OFFLINE;
      beat_d  = '0;
    end else if (state_q == BURST) begin
      dma_win = dma_req;
      cpu_win = cpu_req & ~dma_req;
      if (dma_req) begin
        beat_d = beat_q + BW'(1);
        if (beat_d == BEAT_MAX) begin
          state_d = IDLE;
          beat_d  = '0;
          force_d = 1'b1;
        end else if (!dma_lock) begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
    end else begin
      // IDLE and the first available cycle out of OFFLINE arbitrate identically
      state_d = IDLE;
      dma_win = dma_req & (~cpu_req | ((starve_q == STARVE_MAX) & ~force_q));
      cpu_win = cpu_req & ~dma_win;
      if (dma_win & dma_lock) begin
        state_d = BURST;
        beat_d  = BW'(1);
      end else begin
        beat_d  = '0;
      end
    end
    if (dma_win) begin
      starve_d = '0;
    end else if (cpu_win & dma_req & (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign cpu_gnt          = cpu_win;
  assign dma_gnt          = dma_win;
  assign dma_burst_active = (state_q == BURST);

  always_comb begin
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (dma_win) begin
      sram_req   = 1'b1;
      sram_we    = dma_we;
      sram_be    = dma_be;
      sram_addr  = dma_addr;
      sram_wdata = dma_wdata;
    end else if (cpu_win) begin
      sram_req   = 1'b1;
      sram_we    = cpu_we;
      sram_be    = cpu_be;
      sram_addr  = cpu_addr;
      sram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      starve_q     <= '0;
      force_q      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      starve_q     <= starve_d;
      force_q      <= force_d;
      cpu_rvalid_q <= cpu_win & ~cpu_we;
      dma_rvalid_q <= dma_win & ~dma_we;
      if (cpu_win & ~cpu_we) cpu_rdata_q <= sram_rdata;
      if (dma_win & ~dma_we) dma_rdata_q <= sram_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_be;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [3:0]  dma_be;
  logic [12:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        sram_req, sram_we;
  logic [3:0]  sram_be;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_ready, pd_en, ret_en, mbist_en;
  logic        dma_burst_active;

  logic [31:0] mem [0:2047];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  assign sram_rdata = mem[sram_addr[12:2]];

  sram_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_be(dma_be),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .sram_req(sram_req), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .pd_en(pd_en), .ret_en(ret_en), .mbist_en(mbist_en),
    .dma_burst_active(dma_burst_active)
  );

  task automatic quiet_inputs();
    cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_be = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; quiet_inputs();
    sram_ready = 1; pd_en = 1; ret_en = 0; mbist_en = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, dma_burst_active} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b exp 00000",
        {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, dma_burst_active}); end
    checks++; if ({cpu_rdata, dma_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_rdata: got %h exp 0", {cpu_rdata, dma_rdata}); end
    checks++; if ({sram_req, sram_we, sram_be, sram_addr, sram_wdata} !== 51'h0) begin
      fails++; $display("FAIL reset_sram: got %h exp 0", {sram_req, sram_we, sram_be, sram_addr, sram_wdata}); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_cpu_access();
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_be = 4'hF; cpu_addr = 13'h010; #1;
    checks++; if ({cpu_gnt, dma_gnt, sram_req, sram_we} !== 4'b1010) begin
      fails++; $display("FAIL cpu_rd_gnt: got %b exp 1010", {cpu_gnt, dma_gnt, sram_req, sram_we}); end
    checks++; if (sram_addr !== 13'h010) begin
      fails++; $display("FAIL cpu_rd_addr: got %h exp 010", sram_addr); end
    @(negedge clk);
    cpu_we = 1; cpu_be = 4'h3; cpu_addr = 13'h044; cpu_wdata = 32'h1234_5678; #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA5A5_0001) begin
      fails++; $display("FAIL cpu_rd_data: got %b/%h exp 1/a5a50001", cpu_rvalid, cpu_rdata); end
    checks++; if ({sram_req, sram_we, sram_be, sram_addr, sram_wdata} !== {1'b1, 1'b1, 4'h3, 13'h044, 32'h1234_5678}) begin
      fails++; $display("FAIL cpu_wr_mux: got %h", {sram_req, sram_we, sram_be, sram_addr, sram_wdata}); end
    @(negedge clk);
    quiet_inputs(); #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hA5A5_0001) begin
      fails++; $display("FAIL cpu_wr_norvalid: got %b/%h exp 0/a5a50001", cpu_rvalid, cpu_rdata); end
    checks++; if ({sram_req, sram_addr, sram_wdata} !== 46'h0) begin
      fails++; $display("FAIL idle_sram_zero: got %h exp 0", {sram_req, sram_addr, sram_wdata}); end
  endtask

  task automatic test_starvation();
    logic exp_dma;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1; dma_lock = 0; #1;
      exp_dma = (i == 8) || (i == 17);
      checks++; if (dma_gnt !== exp_dma || cpu_gnt !== !exp_dma) begin
        fails++; $display("FAIL starve_cyc%0d: got cpu=%b dma=%b exp dma=%b", i, cpu_gnt, dma_gnt, exp_dma); end
    end
    @(negedge clk); quiet_inputs();
  endtask

  task automatic test_burst_cap();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 13'(k * 4); cpu_req = (k > 0); cpu_we = 1; #1;
      checks++; if ({dma_gnt, cpu_gnt, dma_burst_active} !== {2'b10, (k > 0)} || sram_addr !== 13'(k * 4)) begin
        fails++; $display("FAIL cap_beat%0d: got gnt=%b%b act=%b addr=%h", k, dma_gnt, cpu_gnt, dma_burst_active, sram_addr); end
    end
    @(negedge clk); #1;
    checks++; if ({dma_gnt, cpu_gnt, dma_burst_active} !== 3'b010) begin
      fails++; $display("FAIL cap_exit: got %b exp 010", {dma_gnt, cpu_gnt, dma_burst_active}); end
    @(negedge clk); cpu_req = 0; #1;
    checks++; if ({dma_gnt, dma_burst_active} !== 2'b10) begin
      fails++; $display("FAIL cap_rearm: got %b exp 10", {dma_gnt, dma_burst_active}); end
    @(negedge clk); dma_lock = 0; #1;
    checks++; if ({dma_gnt, dma_burst_active} !== 2'b11) begin
      fails++; $display("FAIL cap_lastbeat: got %b exp 11", {dma_gnt, dma_burst_active}); end
    @(negedge clk); quiet_inputs(); #1;
    checks++; if (dma_burst_active !== 1'b0) begin
      fails++; $display("FAIL cap_unlock_exit: got %b exp 0", dma_burst_active); end
  endtask

  task automatic test_bubble();
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      dma_we = 1; dma_lock = 1; cpu_we = 1;
      cpu_req = (c > 0);
      dma_req = !(c == 3 || c == 4); #1;
      if (c == 3 || c == 4) begin
        checks++; if ({dma_gnt, cpu_gnt, dma_burst_active} !== 3'b011) begin
          fails++; $display("FAIL bubble_cyc%0d: got %b exp 011", c, {dma_gnt, cpu_gnt, dma_burst_active}); end
      end else if (c < 18) begin
        checks++; if ({dma_gnt, cpu_gnt} !== 2'b10 || dma_burst_active !== (c > 0)) begin
          fails++; $display("FAIL bubble_beat%0d: got %b exp 10%b", c, {dma_gnt, cpu_gnt, dma_burst_active}, (c > 0)); end
      end else begin
        checks++; if ({dma_gnt, cpu_gnt, dma_burst_active} !== 3'b010) begin
          fails++; $display("FAIL bubble_exit: got %b exp 010", {dma_gnt, cpu_gnt, dma_burst_active}); end
      end
    end
    @(negedge clk); quiet_inputs();
  endtask

  task automatic test_offline();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dma_req = 1; dma_lock = 1; dma_we = (c != 3); dma_addr = 13'h020;
    end
    @(negedge clk); mbist_en = 1; #1;
    checks++; if ({dma_gnt, cpu_gnt, sram_req, dma_burst_active} !== 4'b0001) begin
      fails++; $display("FAIL off_nogrant: got %b exp 0001", {dma_gnt, cpu_gnt, sram_req, dma_burst_active}); end
    checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL off_lastread: got %b/%h exp 1/deadbeef", dma_rvalid, dma_rdata); end
    @(negedge clk); cpu_req = 1; cpu_we = 1; #1;
    checks++; if ({dma_gnt, cpu_gnt, sram_req, dma_burst_active, dma_rvalid} !== 5'b0) begin
      fails++; $display("FAIL off_state: got %b exp 00000", {dma_gnt, cpu_gnt, sram_req, dma_burst_active, dma_rvalid}); end
    @(negedge clk); mbist_en = 0; dma_we = 1; #1;
    checks++; if ({dma_gnt, cpu_gnt, sram_req} !== 3'b011) begin
      fails++; $display("FAIL off_resume_cpu: got %b exp 011", {dma_gnt, cpu_gnt, sram_req}); end
    @(negedge clk); cpu_req = 0; dma_lock = 0; #1;
    checks++; if ({dma_gnt, dma_burst_active} !== 2'b10) begin
      fails++; $display("FAIL off_resume_dma: got %b exp 10", {dma_gnt, dma_burst_active}); end
    @(negedge clk); dma_req = 0; cpu_req = 1; ret_en = 1; #1;
    checks++; if ({cpu_gnt, sram_req, dma_burst_active} !== 3'b000) begin
      fails++; $display("FAIL ret_nogrant: got %b exp 000", {cpu_gnt, sram_req, dma_burst_active}); end
    @(negedge clk); ret_en = 0; quiet_inputs();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk); dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 13'h010;
    @(negedge clk); #1;
    checks++; if ({dma_gnt, dma_rvalid, dma_burst_active} !== 3'b111 || dma_rdata !== 32'hA5A5_0001) begin
      fails++; $display("FAIL rst_pre: got %b/%h exp 111/a5a50001", {dma_gnt, dma_rvalid, dma_burst_active}, dma_rdata); end
    #1 rst_n = 0; #1;
    checks++; if ({dma_rvalid, dma_burst_active} !== 2'b00 || dma_rdata !== 32'h0) begin
      fails++; $display("FAIL rst_async: got %b/%h exp 00/0", {dma_rvalid, dma_burst_active}, dma_rdata); end
    @(negedge clk); quiet_inputs(); #1;
    checks++; if ({dma_rvalid, dma_burst_active} !== 2'b00) begin
      fails++; $display("FAIL rst_dropped: got %b exp 00", {dma_rvalid, dma_burst_active}); end
    rst_n = 1;
    @(negedge clk); dma_req = 1; dma_we = 1; dma_lock = 0; #1;
    checks++; if ({dma_gnt, dma_burst_active} !== 2'b10) begin
      fails++; $display("FAIL rst_recover: got %b exp 10", {dma_gnt, dma_burst_active}); end
    @(negedge clk); quiet_inputs();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[4] = 32'hA5A5_0001;
    mem[8] = 32'hDEAD_BEEF;
    test_reset();
    test_cpu_access();
    test_starvation();
    test_burst_cap();
    test_bubble();
    test_offline();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
